// File: rtl/frac_norm_lsh_pipe_if.sv
// Handshake and data bundle for the fraction left-shift pipeline.
// The slave modport is the shifter itself; master is the side that feeds
// fractions in and collects shifted results.
interface frac_norm_lsh_pipe_if #(
    parameter int WIDTH = 52,
    parameter int SHW   = $clog2(WIDTH + 1)
);
    logic             flush_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic             mode_i;
    logic [SHW-1:0]   lsh_i;
    logic [WIDTH-1:0] frac_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] frac_o;
    logic [SHW-1:0]   lsh_o;
    logic             zero_o;

    modport master (
        output flush_i, in_valid_i, mode_i, lsh_i, frac_i, out_ready_i,
        input  in_ready_o, out_valid_o, frac_o, lsh_o, zero_o
    );

    modport slave (
        input  flush_i, in_valid_i, mode_i, lsh_i, frac_i, out_ready_i,
        output in_ready_o, out_valid_o, frac_o, lsh_o, zero_o
    );
endinterface

// File: rtl/frac_norm_lsh_pipe.sv
// Two-stage fraction left shifter for the FP div/sqrt result path.
// Stage p0 resolves the effective shift amount (explicit, or leading-zero
// count capped by a limit so denormal results stop at the exponent floor).
// Stage p1 holds the shifted fraction, the applied amount and a zero flag.
// Full valid/ready back-pressure, one result per cycle, capacity two.
module frac_norm_lsh_pipe #(
    parameter int WIDTH = 52,
    parameter int SHW   = $clog2(WIDTH + 1)
) (
    input logic                clk,
    input logic                rst_n,
    frac_norm_lsh_pipe_if.slave bus
);

    // Leading-zero count from the MSB; an all-zero input counts as WIDTH.
    function automatic logic [SHW-1:0] lzc(input logic [WIDTH-1:0] v);
        logic [SHW-1:0] n;
        n = SHW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) n = SHW'(WIDTH - 1 - i);
        end
        return n;
    endfunction

    // Logarithmic shifter: one 2:1 level per amount bit, MSB level first.
    // Amounts of WIDTH or more shift every bit out, giving zero.
    function automatic logic [WIDTH-1:0] log_shift(input logic [WIDTH-1:0] v,
                                                   input logic [SHW-1:0]   amt);
        logic [WIDTH-1:0] s;
        s = v;
        for (int k = SHW - 1; k >= 0; k--) begin
            if (amt[k]) s = s << (2 ** k);
        end
        return s;
    endfunction

    logic             vld_p0;
    logic [WIDTH-1:0] frac_p0;
    logic [SHW-1:0]   amt_p0;

    logic             vld_p1;
    logic [WIDTH-1:0] frac_p1;
    logic [SHW-1:0]   lsh_p1;
    logic             zero_p1;

    logic             b_accept;
    logic             a_advance;
    logic             in_ready;
    logic             in_xfer;
    logic [SHW-1:0]   lz_in;
    logic [SHW-1:0]   amt_in;
    logic [WIDTH-1:0] frac_shifted;

    assign b_accept  = !vld_p1 || bus.out_ready_i;
    assign a_advance = vld_p0 && b_accept;
    assign in_ready  = !vld_p0 || b_accept;
    assign in_xfer   = bus.in_valid_i && in_ready;

    // Effective shift amount: explicit value, or lzc capped by the limit.
    always_comb begin
        lz_in  = lzc(bus.frac_i);
        amt_in = bus.lsh_i;
        if (bus.mode_i && (lz_in < bus.lsh_i)) amt_in = lz_in;
    end

    // Shift the stage-p0 fraction by its resolved amount.
    always_comb begin
        frac_shifted = log_shift(frac_p0, amt_p0);
    end

    // Stage valid bits; flush wins over any same-cycle transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else if (bus.flush_i) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            if (in_xfer)        vld_p0 <= 1'b1;
            else if (a_advance) vld_p0 <= 1'b0;
            if (b_accept)       vld_p1 <= vld_p0;
        end
    end

    // ---- stage p0: capture fraction and effective amount ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frac_p0 <= '0;
            amt_p0  <= '0;
        end else if (in_xfer) begin
            frac_p0 <= bus.frac_i;
            amt_p0  <= amt_in;
        end
    end

    // ---- stage p1: shifted result, held while downstream stalls ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frac_p1 <= '0;
            lsh_p1  <= '0;
            zero_p1 <= 1'b0;
        end else if (a_advance) begin
            frac_p1 <= frac_shifted;
            lsh_p1  <= amt_p0;
            zero_p1 <= (frac_shifted == '0);
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = vld_p1;
    assign bus.frac_o      = frac_p1;
    assign bus.lsh_o       = lsh_p1;
    assign bus.zero_o      = zero_p1;

endmodule

// File: tb/tb_frac_norm_lsh_pipe.sv
// Directed bench for frac_norm_lsh_pipe (WIDTH=52): explicit and normalize
// shifts, latency, back-pressure, flush and mid-stream reset.
module tb_frac_norm_lsh_pipe;
    localparam int W = 52;
    localparam int S = 6;

    logic clk;
    logic rst_n;

    frac_norm_lsh_pipe_if #(.WIDTH(W), .SHW(S)) bus ();

    frac_norm_lsh_pipe #(.WIDTH(W), .SHW(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Hand-computed vector table.
    logic         vm [0:15];
    logic [S-1:0] vl [0:15];
    logic [W-1:0] vf [0:15];
    logic [W-1:0] ef [0:15];
    logic [S-1:0] el [0:15];
    logic         ez [0:15];

    int exp_q[$];
    int cur_idx;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setv(input int i, input logic m, input logic [S-1:0] l, input logic [W-1:0] f,
                        input logic [W-1:0] xf, input logic [S-1:0] xl, input logic xz);
        vm[i] = m; vl[i] = l; vf[i] = f; ef[i] = xf; el[i] = xl; ez[i] = xz;
    endtask

    task automatic drive(input int i);
        bus.in_valid_i = 1'b1;
        bus.mode_i     = vm[i];
        bus.lsh_i      = vl[i];
        bus.frac_i     = vf[i];
        cur_idx        = i;
    endtask

    // One clock: score the output transfer against the expected queue,
    // record the input transfer, then step past the next rising edge.
    task automatic cycle();
        int k;
        #1;
        if (bus.out_valid_o && bus.out_ready_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 64'd1, 64'd0);
            end else begin
                k = exp_q.pop_front();
                check($sformatf("v%0d_frac", k), 64'(bus.frac_o), 64'(ef[k]));
                check($sformatf("v%0d_lsh", k),  64'(bus.lsh_o),  64'(el[k]));
                check($sformatf("v%0d_zero", k), 64'(bus.zero_o), 64'(ez[k]));
            end
        end
        if (bus.flush_i) exp_q.delete();
        else if (bus.in_valid_i && bus.in_ready_o) exp_q.push_back(cur_idx);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        int guard;
        logic rdy;

        setv(0,  1'b0, 6'd51, 52'h1,             52'h8000000000000, 6'd51, 1'b0);
        setv(1,  1'b0, 6'd52, 52'h1,             52'h0,             6'd52, 1'b1);
        setv(2,  1'b1, 6'd63, 52'hF0,            52'hF000000000000, 6'd44, 1'b0);
        setv(3,  1'b1, 6'd63, 52'h8000000000000, 52'h8000000000000, 6'd0,  1'b0);
        setv(4,  1'b1, 6'd10, 52'hF0,            52'h3C000,         6'd10, 1'b0);
        setv(5,  1'b1, 6'd63, 52'h0,             52'h0,             6'd52, 1'b1);
        setv(6,  1'b1, 6'd63, 52'h1,             52'h8000000000000, 6'd51, 1'b0);
        setv(7,  1'b0, 6'd4,  52'hFFFFFFFFFFFFF, 52'hFFFFFFFFFFFF0, 6'd4,  1'b0);
        setv(8,  1'b1, 6'd50, 52'h3,             52'hC000000000000, 6'd50, 1'b0);
        setv(9,  1'b0, 6'd63, 52'hFFFFFFFFFFFFF, 52'h0,             6'd63, 1'b1);
        setv(10, 1'b1, 6'd5,  52'h100000000,     52'h2000000000,    6'd5,  1'b0);
        setv(11, 1'b0, 6'd1,  52'h1,             52'h2,             6'd1,  1'b0);
        setv(12, 1'b0, 6'd2,  52'h1,             52'h4,             6'd2,  1'b0);
        setv(13, 1'b0, 6'd3,  52'h1,             52'h8,             6'd3,  1'b0);
        setv(14, 1'b0, 6'd4,  52'h1,             52'h10,            6'd4,  1'b0);
        setv(15, 1'b0, 6'd0,  52'h0,             52'h0,             6'd0,  1'b1);

        // Reset state
        rst_n           = 1'b0;
        bus.flush_i     = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.mode_i      = 1'b0;
        bus.lsh_i       = '0;
        bus.frac_i      = '0;
        bus.out_ready_i = 1'b0;
        cur_idx         = 0;
        #3;
        check("rst_in_ready",  64'(bus.in_ready_o),  64'd1);
        check("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("rst_frac",      64'(bus.frac_o),      64'd0);
        check("rst_lsh",       64'(bus.lsh_o),       64'd0);
        check("rst_zero",      64'(bus.zero_o),      64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("post_rst_in_ready", 64'(bus.in_ready_o), 64'd1);

        // Latency: one entry, valid appears after the second edge
        bus.out_ready_i = 1'b1;
        drive(0);
        cycle();
        bus.in_valid_i = 1'b0;
        check("lat_edge1_valid", 64'(bus.out_valid_o), 64'd0);
        cycle();
        check("lat_edge2_valid", 64'(bus.out_valid_o), 64'd1);
        cycle();

        // Back-to-back stream through both modes
        for (int i = 1; i <= 10; i++) begin
            drive(i);
            cycle();
        end
        bus.in_valid_i = 1'b0;
        repeat (3) cycle();
        check("stream_drained", 64'(exp_q.size()), 64'd0);
        check("stream_idle_valid", 64'(bus.out_valid_o), 64'd0);

        // Back-pressure: two accepted, then in_ready drops
        bus.out_ready_i = 1'b0;
        acc = 0;
        for (int j = 0; j < 4; j++) begin
            drive(11 + acc);
            #1;
            rdy = bus.in_ready_o;
            check($sformatf("bp_in_ready_%0d", j), 64'(rdy), (j < 2) ? 64'd1 : 64'd0);
            if (j >= 2) begin
                check($sformatf("bp_hold_valid_%0d", j), 64'(bus.out_valid_o), 64'd1);
                check($sformatf("bp_hold_frac_%0d", j),  64'(bus.frac_o), 64'(ef[11]));
                check($sformatf("bp_hold_lsh_%0d", j),   64'(bus.lsh_o),  64'(el[11]));
            end
            cycle();
            if (rdy) acc++;
        end
        bus.out_ready_i = 1'b1;
        guard = 0;
        while (acc < 4 && guard < 10) begin
            drive(11 + acc);
            #1;
            rdy = bus.in_ready_o;
            cycle();
            if (rdy) acc++;
            guard++;
        end
        check("bp_all_accepted", 64'(acc), 64'd4);
        bus.in_valid_i = 1'b0;
        repeat (4) cycle();
        check("bp_drained", 64'(exp_q.size()), 64'd0);

        // Flush with two entries in flight plus a same-cycle input
        bus.out_ready_i = 1'b0;
        drive(2);
        cycle();
        drive(3);
        cycle();
        check("fl_pre_valid", 64'(bus.out_valid_o), 64'd1);
        drive(4);
        bus.flush_i = 1'b1;
        cycle();
        bus.flush_i    = 1'b0;
        bus.in_valid_i = 1'b0;
        check("fl_valid_after", 64'(bus.out_valid_o), 64'd0);
        check("fl_in_ready",    64'(bus.in_ready_o),  64'd1);
        bus.out_ready_i = 1'b1;
        repeat (4) cycle();
        check("fl_nothing_later", 64'(bus.out_valid_o), 64'd0);

        // Reset asserted mid-stream
        drive(5);
        cycle();
        drive(6);
        cycle();
        check("mr_pre_valid", 64'(bus.out_valid_o), 64'd1);
        rst_n          = 1'b0;
        bus.in_valid_i = 1'b0;
        #1;
        check("mr_valid",    64'(bus.out_valid_o), 64'd0);
        check("mr_frac",     64'(bus.frac_o),      64'd0);
        check("mr_lsh",      64'(bus.lsh_o),       64'd0);
        check("mr_zero",     64'(bus.zero_o),      64'd0);
        check("mr_in_ready", 64'(bus.in_ready_o),  64'd1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mr_release_valid", 64'(bus.out_valid_o), 64'd0);
        drive(7);
        cycle();
        bus.in_valid_i = 1'b0;
        check("mr_edge1_valid", 64'(bus.out_valid_o), 64'd0);
        cycle();
        check("mr_edge2_valid", 64'(bus.out_valid_o), 64'd1);
        cycle();
        check("mr_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
